arb8_pri_rr: RTL and testbench

- Eight-requester arbiter for one shared resource, built around the team's 8-3 priority encoding.
- Each cycle it picks one winner, drives a one-hot grant plus a 3-bit index, and holds that grant until the owner releases or a hold limit expires.
- Two modes, selected by iMode:
  - fixed priority: bit 7 highest, bit 0 lowest, same order as the 8-3 priority encoder;
  - round-robin: rotating priority in the same downward direction.
- Placed between requesting blocks and the shared datapath, which uses oIdx directly as its select.

---
 rtl/arb8_pri_rr_if.sv | 28 ++
 rtl/arb8_pri_rr.sv | 108 ++++++++++
 tb/tb_arb8_pri_rr.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/arb8_pri_rr_if.sv
// Request/grant bundle between the requesting blocks and the eight-way arbiter.
// The master side raises requests; the slave side (the arbiter) returns the grant.
interface arb8_pri_rr_if;
  logic [7:0] iReq;
  logic       iMode;
  logic [7:0] oGrant;
  logic [2:0] oIdx;
  logic       oValid;
  logic       oTimeout;

  modport master (
    output iReq,
    output iMode,
    input  oGrant,
    input  oIdx,
    input  oValid,
    input  oTimeout
  );

  modport slave (
    input  iReq,
    input  iMode,
    output oGrant,
    output oIdx,
    output oValid,
    output oTimeout
  );
endinterface

// File: rtl/arb8_pri_rr.sv
// Eight-requester arbiter: fixed or round-robin priority (downward, bit 7 first),
// grant held until release or MAX_HOLD, then one dead GAP cycle before re-arbitration.
module arb8_pri_rr #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CW       = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  arb8_pri_rr_if.slave bus
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255 || (MAX_HOLD >> CW) != 0) begin : gBadParam
    $error("arb8_pri_rr: MAX_HOLD must be 1..255 and fit in CW bits");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] holdCnt;
  logic [2:0]    last;
  logic          armed;
  logic [7:0]    grantQ;
  logic [2:0]    idxQ;
  logic          validQ;
  logic          timeoutQ;

  logic [2:0]    winIdx_c;
  logic [2:0]    cand_c;

  // Winner search; later hits overwrite earlier ones, so iterate from lowest to highest priority.
  always_comb begin
    winIdx_c = 3'd0;
    cand_c   = 3'd0;
    if (bus.iMode) begin
      for (int k = 8; k >= 1; k--) begin
        cand_c = last - 3'(k);
        if (bus.iReq[cand_c]) winIdx_c = cand_c;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (bus.iReq[i]) winIdx_c = 3'(i);
      end
    end
  end

  // armed keeps the first edge after reset release from issuing a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      holdCnt  <= '0;
      last     <= 3'd0;
      armed    <= 1'b0;
      grantQ   <= 8'd0;
      idxQ     <= 3'd0;
      validQ   <= 1'b0;
      timeoutQ <= 1'b0;
    end else begin
      armed    <= 1'b1;
      timeoutQ <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if ((armed || state == GAP) && (bus.iReq != 8'd0)) begin
            state   <= GRANT;
            grantQ  <= 8'(1) << winIdx_c;
            idxQ    <= winIdx_c;
            validQ  <= 1'b1;
            holdCnt <= CW'(1);
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (!bus.iReq[idxQ]) begin
            state   <= GAP;
            grantQ  <= 8'd0;
            validQ  <= 1'b0;
            last    <= idxQ;
            holdCnt <= '0;
          end else if (holdCnt == CW'(MAX_HOLD)) begin
            state    <= GAP;
            grantQ   <= 8'd0;
            validQ   <= 1'b0;
            last     <= idxQ;
            holdCnt  <= '0;
            timeoutQ <= 1'b1;
          end else begin
            holdCnt <= holdCnt + CW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          grantQ <= 8'd0;
          validQ <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oGrant   = grantQ;
  assign bus.oIdx     = idxQ;
  assign bus.oValid   = validQ;
  assign bus.oTimeout = timeoutQ;

endmodule

// File: tb/tb_arb8_pri_rr.sv
// Directed bench for arb8_pri_rr: one instance with MAX_HOLD=16, one with MAX_HOLD=4,
// both fed the same requests; vector tables say which instance each row checks.
module tb_arb8_pri_rr;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arb8_pri_rr_if bus();
  arb8_pri_rr_if busT();

  arb8_pri_rr #(.MAX_HOLD(16), .CW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  arb8_pri_rr #(.MAX_HOLD(4), .CW(3)) dutT (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busT)
  );

  typedef struct {
    logic [7:0] req;
    logic       mode;
    logic       sel;    // 0: dut (MAX_HOLD=16), 1: dutT (MAX_HOLD=4)
    logic [2:0] idx;
    logic       valid;
    logic       tmo;
  } vec_t;

  vec_t  vq[$];
  int    nChecks = 0;
  int    nPass   = 0;
  string scen    = "init";

  function automatic vec_t mk(logic [7:0] req, logic mode, logic sel,
                              logic [2:0] idx, logic valid, logic tmo);
    vec_t v;
    v.req = req; v.mode = mode; v.sel = sel;
    v.idx = idx; v.valid = valid; v.tmo = tmo;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(logic [7:0] r, logic m);
    bus.iReq   = r;
    busT.iReq  = r;
    bus.iMode  = m;
    busT.iMode = m;
  endtask

  task automatic checkDut(string tag, logic sel, logic [2:0] idx, logic valid, logic tmo);
    logic [7:0] expGrant;
    logic [7:0] g;
    logic [2:0] ix;
    logic       vl;
    logic       to;
    expGrant = valid ? (8'(1) << idx) : 8'd0;
    g  = sel ? busT.oGrant   : bus.oGrant;
    ix = sel ? busT.oIdx     : bus.oIdx;
    vl = sel ? busT.oValid   : bus.oValid;
    to = sel ? busT.oTimeout : bus.oTimeout;
    chk({tag, " grant"},   32'(g),  32'(expGrant));
    chk({tag, " idx"},     32'(ix), 32'(idx));
    chk({tag, " valid"},   32'(vl), 32'(valid));
    chk({tag, " timeout"}, 32'(to), 32'(tmo));
  endtask

  task automatic runVecs();
    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].req, vq[i].mode);
      @(posedge clk);
      #1;
      checkDut($sformatf("%s[%0d]", scen, i), vq[i].sel, vq[i].idx, vq[i].valid, vq[i].tmo);
    end
    vq.delete();
  endtask

  // Leaves both instances idle and past their first post-reset edge.
  task automatic resetDuts();
    @(negedge clk);
    rst_n = 1'b0;
    drive(8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Structural invariants on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("onehot0 dut",  32'($onehot0(bus.oGrant)),  32'(1));
      chk("onehot0 dutT", 32'($onehot0(busT.oGrant)), 32'(1));
      chk("valid==|grant dut",  32'(bus.oValid),  32'(|bus.oGrant));
      chk("valid==|grant dutT", 32'(busT.oValid), 32'(|busT.oGrant));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] full;
    full = 8'hFF;

    // Reset held with all requests up, then idle.
    scen = "reset";
    drive(8'hFF, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkDut("in_reset dut",  1'b0, 3'd0, 1'b0, 1'b0);
    checkDut("in_reset dutT", 1'b1, 3'd0, 1'b0, 1'b0);
    drive(8'h00, 1'b0);
    rst_n = 1'b1;
    scen = "idle";
    repeat (5) vq.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0));
    runVecs();

    // Fixed priority staircase: 4 granted cycles per owner, then a GAP.
    scen = "fixed";
    for (int s = 0; s < 8; s++) begin
      repeat (4) vq.push_back(mk(full >> s, 1'b0, 1'b0, 3'(7 - s), 1'b1, 1'b0));
      vq.push_back(mk(full >> (s + 1), 1'b0, 1'b0, 3'(7 - s), 1'b0, 1'b0));
    end
    repeat (2) vq.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0));
    runVecs();

    // Round-robin over 1010_0101: expected order 7,5,2,0,7,5.
    resetDuts();
    scen = "rr";
    vq.push_back(mk(8'hA5, 1'b1, 1'b0, 3'd7, 1'b1, 1'b0));
    vq.push_back(mk(8'hA5, 1'b1, 1'b0, 3'd7, 1'b1, 1'b0));
    vq.push_back(mk(8'h25, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0));
    vq.push_back(mk(8'hA5, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0));
    vq.push_back(mk(8'hA5, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0));
    vq.push_back(mk(8'h85, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0));
    vq.push_back(mk(8'hA5, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0));
    vq.push_back(mk(8'hA5, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0));
    vq.push_back(mk(8'hA1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0));
    vq.push_back(mk(8'hA5, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0));
    vq.push_back(mk(8'hA5, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0));
    vq.push_back(mk(8'hA4, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0));
    vq.push_back(mk(8'hA5, 1'b1, 1'b0, 3'd7, 1'b1, 1'b0));
    vq.push_back(mk(8'hA5, 1'b1, 1'b0, 3'd7, 1'b1, 1'b0));
    vq.push_back(mk(8'h25, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0));
    vq.push_back(mk(8'hA5, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0));
    vq.push_back(mk(8'hA5, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0));
    vq.push_back(mk(8'h00, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0));
    vq.push_back(mk(8'h00, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0));
    runVecs();

    // Timeout, round-robin: 3 held 4 cycles, revoked, 0 next, then back to 3.
    resetDuts();
    scen = "tmo_rr";
    repeat (4) vq.push_back(mk(8'h09, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0));
    vq.push_back(mk(8'h09, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1));
    repeat (4) vq.push_back(mk(8'h09, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0));
    vq.push_back(mk(8'h09, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1));
    vq.push_back(mk(8'h09, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0));
    vq.push_back(mk(8'h00, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0));
    vq.push_back(mk(8'h00, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0));
    runVecs();

    // Timeout, fixed: same owner re-granted after the gap.
    resetDuts();
    scen = "tmo_fixed";
    repeat (4) vq.push_back(mk(8'h09, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0));
    vq.push_back(mk(8'h09, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1));
    vq.push_back(mk(8'h09, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0));
    vq.push_back(mk(8'h00, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0));
    vq.push_back(mk(8'h00, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0));
    runVecs();

    // No preemption: 7 waits for 1 to release, then one GAP.
    resetDuts();
    scen = "nopreempt";
    vq.push_back(mk(8'h02, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0));
    vq.push_back(mk(8'h02, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0));
    vq.push_back(mk(8'h82, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0));
    vq.push_back(mk(8'h82, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0));
    vq.push_back(mk(8'h80, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0));
    vq.push_back(mk(8'h80, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0));
    vq.push_back(mk(8'h00, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0));
    vq.push_back(mk(8'h00, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0));
    runVecs();

    // Asynchronous reset in the middle of a grant, then no grant on the first edge.
    scen = "async_rst";
    @(negedge clk);
    drive(8'h02, 1'b0);
    @(posedge clk);
    #1;
    checkDut("pre_rst dut",  1'b0, 3'd1, 1'b1, 1'b0);
    checkDut("pre_rst dutT", 1'b1, 3'd1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkDut("async_rst dut",  1'b0, 3'd0, 1'b0, 1'b0);
    checkDut("async_rst dutT", 1'b1, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkDut("first_edge dut",  1'b0, 3'd0, 1'b0, 1'b0);
    checkDut("first_edge dutT", 1'b1, 3'd0, 1'b0, 1'b0);
    vq.push_back(mk(8'h02, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0));
    vq.push_back(mk(8'h00, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0));
    runVecs();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
